branch_resolver: RTL

- Pipelined consumer of comparison semantics: accepts branch requests (operands, PC, offset, comparison opcode) over a valid/ready handshake.
- Evaluates the branch condition and resolves taken/not-taken, target and next PC.
- Sits between decode/issue and the PC-update logic, downstream of the ALU operand path.
- Uses the same 4-bit comparison opcode encoding as the ALU comparison path, so decode feeds both from one field.

---
 rtl/branch_resolver.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/branch_resolver.sv
// Two-stage branch resolver: S1 captures the request, S2 holds the resolved result.
// The condition is evaluated from the S1 registers. All outputs are driven from S2 registers.
// The optional statistics counters are built only when BRANCH_RESOLVER_STATS_EN is defined.
module branch_resolver #(
   parameter int unsigned OPD_LENGTH  = 32,
   parameter int unsigned ADDR_LENGTH = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [3:0]             br_op,
   input  logic [OPD_LENGTH-1:0]  opd1,
   input  logic [OPD_LENGTH-1:0]  opd2,
   input  logic [ADDR_LENGTH-1:0] pc,
   input  logic [ADDR_LENGTH-1:0] offset,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   out_taken,
   output logic [ADDR_LENGTH-1:0] out_target,
   output logic [ADDR_LENGTH-1:0] out_next_pc,
   output logic                   out_illegal,
   output logic                   out_misaligned
`ifdef BRANCH_RESOLVER_STATS_EN
   ,
   output logic [31:0]            stat_total,
   output logic [31:0]            stat_taken
`endif
);

   logic                   s1_valid_q, s1_valid_d;
   logic [3:0]             s1_op_q, s1_op_d;
   logic [OPD_LENGTH-1:0]  s1_opd1_q, s1_opd1_d, s1_opd2_q, s1_opd2_d;
   logic [ADDR_LENGTH-1:0] s1_pc_q, s1_pc_d, s1_off_q, s1_off_d;

   logic                   s2_valid_q, s2_valid_d;
   logic                   s2_taken_q, s2_taken_d;
   logic [ADDR_LENGTH-1:0] s2_target_q, s2_target_d, s2_next_q, s2_next_d;
   logic                   s2_illegal_q, s2_illegal_d;
   logic                   s2_mis_q, s2_mis_d;

   logic                   accept, s2_load, drain;
   logic                   cond, illegal, taken, misaligned;
   logic [ADDR_LENGTH-1:0] target, fallthru, next_pc;

   // in_ready is held low during reset and flush; S1 frees whenever S2 can take its content
   assign in_ready = rst_n && !flush && (!s1_valid_q || !s2_valid_q || out_ready);
   assign accept   = in_valid && in_ready;
   assign s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
   assign drain    = s2_valid_q && out_ready;

   // Branch condition and result fields from the S1 registers
   always_comb begin
      cond    = 1'b0;
      illegal = (s1_op_q[2:1] == 2'b10);
      case (s1_op_q[2:0])
         3'b000:  cond = (s1_opd1_q == s1_opd2_q);
         3'b001:  cond = (s1_opd1_q != s1_opd2_q);
         3'b010:  cond = ($signed(s1_opd1_q) >= $signed(s1_opd2_q));
         3'b011:  cond = ($signed(s1_opd1_q) <  $signed(s1_opd2_q));
         3'b110:  cond = (s1_opd1_q >= s1_opd2_q);
         3'b111:  cond = (s1_opd1_q <  s1_opd2_q);
         default: cond = 1'b0;
      endcase
      // Illegal encodings are never taken, even with bit3 set
      taken      = !illegal && (s1_op_q[3] || cond);
      target     = s1_pc_q + s1_off_q;
      fallthru   = s1_pc_q + ADDR_LENGTH'(4);
      next_pc    = taken ? target : fallthru;
      misaligned = taken && (target[1:0] != 2'b00);
   end

   // Next-state for both stages; flush kills both valid flags and blocks data loads
   always_comb begin
      s1_valid_d   = s1_valid_q;
      s1_op_d      = s1_op_q;
      s1_opd1_d    = s1_opd1_q;
      s1_opd2_d    = s1_opd2_q;
      s1_pc_d      = s1_pc_q;
      s1_off_d     = s1_off_q;
      s2_valid_d   = s2_valid_q;
      s2_taken_d   = s2_taken_q;
      s2_target_d  = s2_target_q;
      s2_next_d    = s2_next_q;
      s2_illegal_d = s2_illegal_q;
      s2_mis_d     = s2_mis_q;
      if (flush) begin
         s1_valid_d = 1'b0;
         s2_valid_d = 1'b0;
      end else begin
         if (accept) begin
            s1_valid_d = 1'b1;
            s1_op_d    = br_op;
            s1_opd1_d  = opd1;
            s1_opd2_d  = opd2;
            s1_pc_d    = pc;
            s1_off_d   = offset;
         end else if (s2_load) begin
            s1_valid_d = 1'b0;
         end
         if (s2_load) begin
            s2_valid_d   = 1'b1;
            s2_taken_d   = taken;
            s2_target_d  = target;
            s2_next_d    = next_pc;
            s2_illegal_d = illegal;
            s2_mis_d     = misaligned;
         end else if (drain) begin
            s2_valid_d = 1'b0;
         end
      end
   end

   // Pipeline registers with asynchronous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q   <= 1'b0;
         s1_op_q      <= '0;
         s1_opd1_q    <= '0;
         s1_opd2_q    <= '0;
         s1_pc_q      <= '0;
         s1_off_q     <= '0;
         s2_valid_q   <= 1'b0;
         s2_taken_q   <= 1'b0;
         s2_target_q  <= '0;
         s2_next_q    <= '0;
         s2_illegal_q <= 1'b0;
         s2_mis_q     <= 1'b0;
      end else begin
         s1_valid_q   <= s1_valid_d;
         s1_op_q      <= s1_op_d;
         s1_opd1_q    <= s1_opd1_d;
         s1_opd2_q    <= s1_opd2_d;
         s1_pc_q      <= s1_pc_d;
         s1_off_q     <= s1_off_d;
         s2_valid_q   <= s2_valid_d;
         s2_taken_q   <= s2_taken_d;
         s2_target_q  <= s2_target_d;
         s2_next_q    <= s2_next_d;
         s2_illegal_q <= s2_illegal_d;
         s2_mis_q     <= s2_mis_d;
      end
   end

   assign out_valid      = s2_valid_q;
   assign out_taken      = s2_taken_q;
   assign out_target     = s2_target_q;
   assign out_next_pc    = s2_next_q;
   assign out_illegal    = s2_illegal_q;
   assign out_misaligned = s2_mis_q;

`ifdef BRANCH_RESOLVER_STATS_EN
   logic [31:0] stat_total_q, stat_total_d, stat_taken_q, stat_taken_d;

   // Handshake counters; they count every drain and ignore flush
   always_comb begin
      stat_total_d = stat_total_q;
      stat_taken_d = stat_taken_q;
      if (drain) begin
         stat_total_d = stat_total_q + 32'd1;
         if (s2_taken_q) stat_taken_d = stat_taken_q + 32'd1;
      end
   end

   // Counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_total_q <= '0;
         stat_taken_q <= '0;
      end else begin
         stat_total_q <= stat_total_d;
         stat_taken_q <= stat_taken_d;
      end
   end

   assign stat_total = stat_total_q;
   assign stat_taken = stat_taken_q;
`endif

endmodule
